// File: rtl/mem_arbiter_if.sv
// Request, response and memory-side signals of the two-port memory arbiter.
// slave is the arbiter's view; master is the requesters-plus-memory view.
interface mem_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  i_req;
  logic [ADDR_WIDTH-1:0] i_addr;
  logic [DATA_WIDTH-1:0] i_rdata;
  logic                  i_ack;
  logic                  i_err;

  logic                  d_req;
  logic                  d_we;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic [DATA_WIDTH-1:0] d_wdata;
  logic [DATA_WIDTH-1:0] d_rdata;
  logic                  d_ack;
  logic                  d_err;

  logic                  mem_read;
  logic                  mem_write;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_resp;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_resp,
    output i_rdata, i_ack, i_err, d_rdata, d_ack, d_err,
           mem_read, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_resp,
    input  i_rdata, i_ack, i_err, d_rdata, d_ack, d_err,
           mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter between a fetch port (I) and a load/store port (D) that
// sequences one strobed transaction at a time into a single-port memory model.
module mem_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_t;

  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t                state;
  logic                  grant_d;
  logic                  last_grant_d;
  logic                  op_write;
  logic                  timed_out;
  logic [WD_W-1:0]       wd_cnt;
  logic                  watchdog_expired;
  logic                  pick_d;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [DATA_WIDTH-1:0] capture_data;
  logic [DATA_WIDTH-1:0] i_rdata_q;
  logic [DATA_WIDTH-1:0] d_rdata_q;

  // D wins when it is alone, or on a tie when I was served last.
  always_comb begin
    pick_d   = bus.d_req && (!bus.i_req || !last_grant_d);
    win_addr = pick_d ? bus.d_addr : bus.i_addr;
  end

  generate
    if (TIMEOUT > 0) begin : g_watchdog
      assign watchdog_expired = (wd_cnt == WD_W'(TIMEOUT - 1));
    end else begin : g_no_watchdog
      assign watchdog_expired = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      grant_d       <= 1'b0;
      last_grant_d  <= 1'b1;
      op_write      <= 1'b0;
      timed_out     <= 1'b0;
      wd_cnt        <= '0;
      i_rdata_q     <= '0;
      d_rdata_q     <= '0;
      bus.mem_read  <= 1'b0;
      bus.mem_write <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.i_ack     <= 1'b0;
      bus.i_err     <= 1'b0;
      bus.d_ack     <= 1'b0;
      bus.d_err     <= 1'b0;
    end else begin
      bus.i_ack <= 1'b0;
      bus.i_err <= 1'b0;
      bus.d_ack <= 1'b0;
      bus.d_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.i_req || bus.d_req) begin
            grant_d       <= pick_d;
            last_grant_d  <= pick_d;
            op_write      <= pick_d && bus.d_we;
            timed_out     <= 1'b0;
            wd_cnt        <= '0;
            bus.mem_addr  <= win_addr;
            bus.mem_wdata <= bus.d_wdata;
            bus.mem_write <= pick_d && bus.d_we;
            bus.mem_read  <= !(pick_d && bus.d_we);
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          // A response in the expiry cycle still counts as a clean completion.
          if (bus.mem_resp || watchdog_expired) begin
            bus.mem_read  <= 1'b0;
            bus.mem_write <= 1'b0;
            timed_out     <= !bus.mem_resp;
            bus.i_ack     <= !grant_d;
            bus.d_ack     <= grant_d;
            bus.i_err     <= !grant_d && !bus.mem_resp;
            bus.d_err     <= grant_d && !bus.mem_resp;
            state         <= CAPTURE;
          end else begin
            wd_cnt <= wd_cnt + WD_W'(1);
          end
        end
        CAPTURE: begin
          if (!op_write && !grant_d) i_rdata_q <= capture_data;
          if (!op_write && grant_d)  d_rdata_q <= capture_data;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read data only arrives during CAPTURE, so it is forwarded alongside the
  // registered ack and latched for the hold period that follows.
  always_comb begin
    capture_data = timed_out ? '0 : bus.mem_rdata;
    bus.i_rdata  = i_rdata_q;
    bus.d_rdata  = d_rdata_q;
    if (state == CAPTURE && !op_write) begin
      if (grant_d) bus.d_rdata = capture_data;
      else         bus.i_rdata = capture_data;
    end
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter and sequencer for the single-port testbench memory model: instruction-fetch port (I, read-only) and load/store port (D, read/write).
- Converts level req/ack handshakes into the memory's edge-triggered read/write strobes, waits for the memory's one-cycle resp pulse, and returns read data and ack to the winning requester.
- Sits between the core's fetch/LSU and the memory model in the core-level bench.

Parameters:
- DATA_WIDTH, 32, width of all data buses.
- ADDR_WIDTH, 32, width of all address buses.
- TIMEOUT, 0, maximum ISSUE cycles before abort with error; 0 disables the watchdog.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- i_req  in  1  fetch request, held with i_addr stable until i_ack
- i_addr  in  ADDR_WIDTH  fetch address
- i_rdata  out  DATA_WIDTH  fetch data, valid when i_ack=1
- i_ack  out  1  one-cycle completion pulse
- i_err  out  1  timeout flag, valid with i_ack
- d_req  in  1  load/store request, held with d_we/d_addr/d_wdata stable until d_ack
- d_we  in  1  1=write, 0=read
- d_addr  in  ADDR_WIDTH  load/store address
- d_wdata  in  DATA_WIDTH  store data
- d_rdata  out  DATA_WIDTH  load data, valid when d_ack=1
- d_ack  out  1  one-cycle completion pulse
- d_err  out  1  timeout flag, valid with d_ack
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- mem_addr  out  ADDR_WIDTH  memory address
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_rdata  in  DATA_WIDTH  memory read data, valid the cycle after mem_resp
- mem_resp  in  1  memory done pulse

Behaviour:
- Reset (rst_n=0 at posedge):
  - state=IDLE; all outputs 0 (acks, errs, strobes, mem_addr, mem_wdata, rdata regs).
  - last_grant=D; watchdog count=0.
  - Reset mid-transaction aborts it silently: no ack. The memory shares rst_n.
- State machine:
  - IDLE → ISSUE when i_req or d_req is high.
  - ISSUE → CAPTURE on mem_resp=1, or on watchdog expiry.
  - CAPTURE → IDLE, unconditionally.
- Arbitration (IDLE only):
  - If only one request is pending, grant it.
  - If both are pending, grant the port that is not last_grant (round-robin). After reset, the first tie goes to I.
  - last_grant updates on each grant. No preemption once in ISSUE.
- Grant registers (on the IDLE→ISSUE edge):
  - mem_addr ← winner address; mem_wdata ← d_wdata.
  - op = write only if the winner is D and d_we=1.
  - Registers are held stable through ISSUE and CAPTURE.
- ISSUE:
  - Assert exactly one strobe (mem_write if op=write, else mem_read). The strobes are never both high.
  - The strobe stays high through the cycle mem_resp is sampled high, because the memory latches read data only while read is asserted at DONE.
  - The strobe is low in IDLE and CAPTURE. This guarantees ≥1 low cycle between transactions, so the memory sees a rising edge for each new transaction.
- Watchdog (TIMEOUT>0):
  - Counts ISSUE cycles, cleared on entry to ISSUE.
  - When count reaches TIMEOUT with no mem_resp, go to CAPTURE with err=1. The strobe drops.
  - mem_resp and expiry in the same cycle: mem_resp wins, err=0.
- CAPTURE:
  - Latch mem_rdata into the winner's rdata register (reads only; writes leave rdata unchanged; timeouts drive rdata 0).
  - Pulse the winner's ack for exactly 1 cycle, with its err. The loser sees ack=0.
- Latency:
  - Request seen in IDLE at cycle t → strobe high at t+1 → ack at (cycle mem_resp sampled)+1.
  - Minimum ack-to-ack spacing is 3 cycles with back-to-back resp.
- A requester may keep req high after ack to issue its next transaction. It is re-arbitrated in the next IDLE cycle.
- A req dropped before ack is a protocol violation; behaviour is unspecified and the bench must not do it.
- rdata outputs hold their last value between acks.

Test Plan:
- Memory DELAY=3, I fetches addr 0x10 alone → mem_read high from t+1 until the cycle mem_resp=1; i_ack one cycle later; i_rdata = mem bytes {0x13,0x12,0x11,0x10}; d_ack stays 0.
- D write: d_we=1, d_addr=0x20, d_wdata=0xDEADBEEF → mem_write high, mem_read never high, mem_wdata=0xDEADBEEF; d_ack pulses once; d_rdata unchanged.
- i_req and d_req both held high continuously for 6 transactions after reset → grant order I,D,I,D,I,D; mem_read low ≥1 cycle between every pair of strobes.
- Back-to-back fetches 0x0, 0x4, 0x8 with req held high → three i_ack pulses; i_rdata matches each word in order; ack-to-ack ≥3 cycles.
- TIMEOUT=5, mem_resp tied 0, D read 0x40 → after 5 ISSUE cycles mem_read drops; next cycle d_ack=1, d_err=1, d_rdata=0; arbiter back in IDLE.
- rst_n=0 for one cycle while in ISSUE → all outputs 0 next cycle; no ack for the aborted transaction; a fresh I request after reset completes normally.
